// File: rtl/cdb_arbiter.sv
// Common data bus transmit arbiter.
// Each functional unit feeds a 2-entry result FIFO. A round-robin scan picks
// one non-empty FIFO per cycle, and its head goes into the registered CDB
// broadcast. Results tagged 0 carry no consumer, so they are accepted and
// then discarded without being queued.
module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 3,
    parameter int XLEN   = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      flush,
    input  logic [NUM_FU-1:0]         fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]   fu_tag,
    input  logic [NUM_FU*XLEN-1:0]    fu_val,
    input  logic [NUM_FU*5-1:0]       fu_rd,
    output logic [NUM_FU-1:0]         fu_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [XLEN-1:0]           cdb_val,
    output logic [4:0]                cdb_rd
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [TAG_W-1:0]  q_tag [NUM_FU][2];
    logic [XLEN-1:0]   q_val [NUM_FU][2];
    logic [4:0]        q_rd  [NUM_FU][2];
    logic [1:0]        count [NUM_FU];
    logic [NUM_FU-1:0] wr_ptr;
    logic [NUM_FU-1:0] rd_ptr;
    logic [PTR_W-1:0]  rr_ptr;

    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic              gnt_valid;
    logic [PTR_W-1:0]  gnt_idx;
    logic [PTR_W-1:0]  scan_idx;
    logic [PTR_W-1:0]  rr_next;

    // Ready comes from the FIFO count only; tag-0 results and flush cycles never write.
    always_comb begin
        fu_ready = '0;
        push     = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready[i] = (count[i] < 2'd2);
            push[i]     = fu_valid[i] && fu_ready[i] && !flush &&
                          (fu_tag[i*TAG_W +: TAG_W] != '0);
        end
    end

    // Round-robin scan from rr_ptr: first non-empty FIFO wins the bus.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        pop       = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_FU);
            if (!gnt_valid && (count[scan_idx] != 2'd0)) begin
                gnt_valid = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
        if (gnt_valid) begin
            pop[gnt_idx] = 1'b1;
        end
        rr_next = (gnt_idx == PTR_W'(NUM_FU - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end

    // FIFO storage; contents are don't-care while count is zero, so no reset.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                q_tag[i][wr_ptr[i]] <= fu_tag[i*TAG_W +: TAG_W];
                q_val[i][wr_ptr[i]] <= fu_val[i*XLEN +: XLEN];
                q_rd[i][wr_ptr[i]]  <= fu_rd[i*5 +: 5];
            end
        end
    end

    // FIFO bookkeeping, round-robin pointer and the registered broadcast.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_FU; i++) begin
                count[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_val   <= '0;
            cdb_rd    <= '0;
        end else if (flush) begin
            // Squash everything pending; rr_ptr keeps its position.
            for (int i = 0; i < NUM_FU; i++) begin
                count[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cdb_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                count[i] <= count[i] + {1'b0, push[i]} - {1'b0, pop[i]};
                if (push[i]) begin
                    wr_ptr[i] <= ~wr_ptr[i];
                end
                if (pop[i]) begin
                    rd_ptr[i] <= ~rd_ptr[i];
                end
            end
            cdb_valid <= gnt_valid;
            if (gnt_valid) begin
                cdb_tag <= q_tag[gnt_idx][rd_ptr[gnt_idx]];
                cdb_val <= q_val[gnt_idx][rd_ptr[gnt_idx]];
                cdb_rd  <= q_rd[gnt_idx][rd_ptr[gnt_idx]];
                rr_ptr  <= rr_next;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter. Bits [31:28] of each value name a stream (one per FU
// per scenario); the scoreboard keeps per-stream order and flags any broadcast
// that has no pending expectation.
module tb_cdb_arbiter;

    localparam int NUM_FU = 4;
    localparam int TAG_W  = 3;
    localparam int XLEN   = 32;

    logic                    CLK = 1'b0;
    logic                    RST;
    logic                    flush;
    logic [NUM_FU-1:0]       fu_valid;
    logic [NUM_FU*TAG_W-1:0] fu_tag;
    logic [NUM_FU*XLEN-1:0]  fu_val;
    logic [NUM_FU*5-1:0]     fu_rd;
    logic [NUM_FU-1:0]       fu_ready;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [XLEN-1:0]         cdb_val;
    logic [4:0]              cdb_rd;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  val;
        logic [4:0]       rd;
    } ent_t;

    ent_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    cdb_arbiter #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_val(fu_val), .fu_rd(fu_rd),
        .fu_ready(fu_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_rd(cdb_rd)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in();
        fu_valid = '0;
        fu_tag   = '0;
        fu_val   = '0;
        fu_rd    = '0;
        flush    = 1'b0;
    endtask

    task automatic set_fu(input int i, input logic [TAG_W-1:0] t,
                          input logic [XLEN-1:0] v, input logic [4:0] r);
        fu_valid[i]              = 1'b1;
        fu_tag[i*TAG_W +: TAG_W] = t;
        fu_val[i*XLEN +: XLEN]   = v;
        fu_rd[i*5 +: 5]          = r;
    endtask

    task automatic expect_ent(input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v,
                              input logic [4:0] r);
        ent_t e;
        e.tag = t;
        e.val = v;
        e.rd  = r;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int max_cyc, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            step();
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: match each broadcast to the oldest pending entry of its stream.
    always @(negedge CLK) begin
        int j;
        if (!RST && cdb_valid) begin
            j = -1;
            for (int k = 0; k < exp_q.size(); k++) begin
                if (exp_q[k].val[31:28] == cdb_val[31:28]) begin
                    j = k;
                    break;
                end
            end
            if (j < 0) begin
                chk("spurious_bcast_valid", 64'(cdb_valid), 64'd0);
            end else begin
                chk("bcast_tag", 64'(cdb_tag), 64'(exp_q[j].tag));
                chk("bcast_val", 64'(cdb_val), 64'(exp_q[j].val));
                chk("bcast_rd",  64'(cdb_rd),  64'(exp_q[j].rd));
                exp_q.delete(j);
            end
        end
    end

    int rem [NUM_FU];
    int seq [NUM_FU];
    int fu0_acc;
    int held;
    int rem_total;
    logic [NUM_FU-1:0] acc;
    logic [XLEN-1:0] v;
    int rr_order [4] = '{2, 3, 0, 1};

    initial begin
        clear_in();
        RST = 1'b1;
        #2;
        chk("reset_valid", 64'(cdb_valid), 64'd0);
        chk("reset_ready", 64'(fu_ready), 64'hF);
        chk("reset_tag",   64'(cdb_tag), 64'd0);
        chk("reset_val",   64'(cdb_val), 64'd0);
        chk("reset_rd",    64'(cdb_rd), 64'd0);
        step();
        step();
        RST = 1'b0;
        step();

        // Single result from FU1: visible after the second edge, for one cycle.
        set_fu(1, 3'd3, 32'hDEADBEEF, 5'd5);
        expect_ent(3'd3, 32'hDEADBEEF, 5'd5);
        step();
        clear_in();
        chk("single_lat0", 64'(cdb_valid), 64'd0);
        step();
        chk("single_valid", 64'(cdb_valid), 64'd1);
        chk("single_tag",   64'(cdb_tag), 64'd3);
        chk("single_val",   64'(cdb_val), 64'hDEADBEEF);
        chk("single_rd",    64'(cdb_rd), 64'd5);
        step();
        chk("single_one_cycle", 64'(cdb_valid), 64'd0);
        chk("single_hold_tag",  64'(cdb_tag), 64'd3);

        // Round robin: FU1 was last granted, so the scan starts at FU2.
        for (int i = 0; i < NUM_FU; i++) begin
            v = (32'(i + 1) << 28) | 32'(i);
            set_fu(i, 3'(i + 4), v, 5'(i + 10));
            expect_ent(3'(i + 4), v, 5'(i + 10));
        end
        step();
        clear_in();
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rr_valid", 64'(cdb_valid), 64'd1);
            chk("rr_order", 64'(cdb_val[31:28]), 64'(rr_order[c] + 1));
        end
        step();
        chk("rr_idle", 64'(cdb_valid), 64'd0);
        drain(4, "rr_drain");

        // Backpressure: FU0 sends 3 while FUs 1..3 keep the bus busy.
        rem = '{3, 4, 4, 4};
        seq = '{0, 0, 0, 0};
        fu0_acc = 0;
        held = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            clear_in();
            for (int i = 0; i < NUM_FU; i++) begin
                if (rem[i] > 0) begin
                    v = (32'(5 + i) << 28) | 32'(seq[i]);
                    set_fu(i, 3'((seq[i] % 7) + 1), v, 5'(i * 4 + seq[i]));
                end
            end
            acc = fu_valid & fu_ready;
            if (fu_valid[0] && !fu_ready[0]) held++;
            for (int i = 0; i < NUM_FU; i++) begin
                if (acc[i]) begin
                    v = (32'(5 + i) << 28) | 32'(seq[i]);
                    expect_ent(3'((seq[i] % 7) + 1), v, 5'(i * 4 + seq[i]));
                    seq[i]++;
                    rem[i]--;
                end
            end
            step();
            if (acc[0]) begin
                fu0_acc++;
                if (fu0_acc == 2) chk("bp_ready0_low", 64'(fu_ready[0]), 64'd0);
            end
        end
        clear_in();
        rem_total = rem[0] + rem[1] + rem[2] + rem[3];
        chk("bp_all_fed", 64'(rem_total), 64'd0);
        chk("bp_third_held", 64'(held > 0), 64'd1);
        drain(60, "bp_drain");

        // Tag 0 is accepted but never broadcast.
        set_fu(2, 3'd0, 32'hE0000000, 5'd1);
        chk("tag0_ready_before", 64'(fu_ready[2]), 64'd1);
        step();
        clear_in();
        chk("tag0_ready_after", 64'(fu_ready[2]), 64'd1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("tag0_no_bcast", 64'(cdb_valid), 64'd0);
        end

        // Flush with two results queued and FU3 pushing in the same cycle.
        set_fu(0, 3'd1, 32'h90000000, 5'd1);
        set_fu(1, 3'd2, 32'h90000001, 5'd2);
        step();
        clear_in();
        flush = 1'b1;
        set_fu(3, 3'd3, 32'hA0000000, 5'd3);
        step();
        clear_in();
        chk("flush_valid", 64'(cdb_valid), 64'd0);
        chk("flush_ready", 64'(fu_ready), 64'hF);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("flush_quiet", 64'(cdb_valid), 64'd0);
        end

        // Reset in the middle of a burst: queued results are discarded.
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                v = (32'(i + 1) << 28) | 32'(c);
                set_fu(i, 3'(i + 1), v, 5'(c));
                expect_ent(3'(i + 1), v, 5'(c));
            end
            step();
        end
        clear_in();
        step();
        #1;
        RST = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(cdb_valid), 64'd0);
        chk("rst_mid_ready", 64'(fu_ready), 64'hF);
        exp_q.delete();
        step();
        RST = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("rst_no_stale", 64'(cdb_valid), 64'd0);
        end

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
